mem_responder: RTL and testbench



---
 rtl/mem_resp_pkg.sv | 28 ++
 rtl/mem_lane_align.sv | 44 ++++
 rtl/mem_responder.sv | 138 +++++++++++++
 tb/tb_mem_responder.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for the data-memory responder.
// Encodes access sizes, FSM states and the byte width of each access size.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  function automatic logic [3:0] size_bytes(input size_e sz);
    case (sz)
      SZ_B:    return 4'd1;
      SZ_H:    return 4'd2;
      SZ_W:    return 4'd4;
      SZ_D:    return 4'd8;
      default: return 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Lane steering for one doubleword: extended load value, merged store word, alignment flag.
// Purely combinational; little-endian byte lanes selected by the low address bits.
module mem_lane_align
  import mem_resp_pkg::*;
(
  input  logic [63:0] dword_i,
  input  logic [2:0]  lane_i,
  input  size_e       size_i,
  input  logic        unsigned_i,
  input  logic [63:0] wdata_i,
  output logic [63:0] load_o,
  output logic [63:0] merged_o,
  output logic        misaligned_o
);

  logic [3:0]  nbytes_s;
  logic [7:0]  lane_mask_s;
  logic [63:0] rsh_s;
  logic [63:0] wsh_s;
  logic [63:0] bmask_s;

  // Shift data to/from the lane, build the byte-enable mask and extend the load.
  always_comb begin
    nbytes_s     = size_bytes(size_i);
    rsh_s        = dword_i >> {lane_i, 3'b000};
    wsh_s        = wdata_i << {lane_i, 3'b000};
    misaligned_o = (({1'b0, lane_i}) & (nbytes_s - 4'd1)) != 4'd0;
    // Truncation only matters for misaligned accesses, which never write.
    lane_mask_s  = 8'(((9'd1 << nbytes_s) - 9'd1) << lane_i);
    bmask_s      = 64'd0;
    for (int i = 0; i < 8; i++) begin
      bmask_s[8*i +: 8] = {8{lane_mask_s[i]}};
    end
    merged_o = (dword_i & ~bmask_s) | (wsh_s & bmask_s);
    case (size_i)
      SZ_B:    load_o = unsigned_i ? {56'd0, rsh_s[7:0]}  : {{56{rsh_s[7]}},  rsh_s[7:0]};
      SZ_H:    load_o = unsigned_i ? {48'd0, rsh_s[15:0]} : {{48{rsh_s[15]}}, rsh_s[15:0]};
      SZ_W:    load_o = unsigned_i ? {32'd0, rsh_s[31:0]} : {{32{rsh_s[31]}}, rsh_s[31:0]};
      SZ_D:    load_o = rsh_s;
      default: load_o = rsh_s;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Data-memory responder: valid/ready load/store port over a doubleword array with LATENCY wait cycles.
// The access (array read-modify-write and response capture) happens on the WAIT->RESP edge.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, uns_q;
  logic [63:0] addr_q, wdata_q;
  size_e       size_q;
  logic        req_ready_q, rsp_valid_q, err_q, err_d;
  logic [63:0] rdata_q, rdata_d;
  logic        accept_s, access_s;
  logic [63:0] mem_q [DEPTH];

  logic [AW-1:0] idx_s;
  logic [63:0]   word_s, load_s, merged_s;
  logic          misal_s, oor_s, err_s;

  assign idx_s  = addr_q[AW+2:3];
  assign oor_s  = (addr_q[63:3] >= 61'(DEPTH));
  assign word_s = oor_s ? 64'd0 : mem_q[idx_s];
  assign err_s  = misal_s | oor_s;

  mem_lane_align u_align (
    .dword_i      (word_s),
    .lane_i       (addr_q[2:0]),
    .size_i       (size_q),
    .unsigned_i   (uns_q),
    .wdata_i      (wdata_q),
    .load_o       (load_s),
    .merged_o     (merged_s),
    .misaligned_o (misal_s)
  );

  // Next-state, wait counter and response capture.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_s = 1'b0;
    access_s = 1'b0;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept_s = 1'b1;
          cnt_d    = 4'(LATENCY - 1);
          state_d  = WAIT;
        end else begin
          state_d  = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          access_s = 1'b1;
          state_d  = RESP;
          err_d    = err_s;
          rdata_d  = (err_s || we_q) ? 64'd0 : load_s;
        end else begin
          cnt_d    = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state, registered handshake outputs and latched request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 64'd0;
      err_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 64'd0;
      size_q      <= SZ_B;
      uns_q       <= 1'b0;
      wdata_q     <= 64'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= (state_d == IDLE);
      rsp_valid_q <= (state_d == RESP);
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      if (accept_s) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        size_q  <= size_e'(req_size);
        uns_q   <= req_unsigned;
        wdata_q <= req_wdata;
      end
    end
  end

  // Array write; a reset arriving on the commit edge discards the store.
  always_ff @(posedge clk) begin
    if (access_s && we_q && !err_s && !reset) begin
      mem_q[idx_s] <= merged_s;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: expectations queued at accept, checked when the response appears.
module tb_mem_responder;
  import mem_resp_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [63:0] rsp_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [63:0] data;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  mem_responder #(.DEPTH(256), .LATENCY(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input logic we, input logic [63:0] addr, input logic [1:0] size,
                           input logic uns, input logic [63:0] wdata);
    req_valid    = 1'b1;
    req_we       = we;
    req_addr     = addr;
    req_size     = size;
    req_unsigned = uns;
    req_wdata    = wdata;
  endtask

  // Accepts one request, queues its expectation, scrambles the bus and checks response latency.
  task automatic issue(input string tag, input logic we, input logic [63:0] addr, input logic [1:0] size,
                       input logic uns, input logic [63:0] wdata,
                       input logic [63:0] exp_data, input logic exp_err);
    int   n;
    exp_t e;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check_val({tag, "_rdy"}, 64'(req_ready), 64'd1);
    drive_req(we, addr, size, uns, wdata);
    @(posedge clk);
    e.data = exp_data;
    e.err  = exp_err;
    sb_q.push_back(e);
    #1;
    req_valid    = 1'b0;
    req_we       = ~we;
    req_addr     = 64'hFFFF_FFFF_FFFF_FFF8;
    req_size     = ~size;
    req_unsigned = ~uns;
    req_wdata    = ~wdata;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check_val({tag, "_lat"}, 64'(n), 64'd2);
  endtask

  task automatic consume(input string tag);
    exp_t e;
    check_val({tag, "_sbq"}, 64'(sb_q.size()), 64'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val({tag, "_data"}, rsp_rdata, e.data);
      check_val({tag, "_err"}, 64'(rsp_err), 64'(e.err));
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check_val({tag, "_vclr"}, 64'(rsp_valid), 64'd0);
    check_val({tag, "_ridle"}, 64'(req_ready), 64'd1);
  endtask

  task automatic xfer(input string tag, input logic we, input logic [63:0] addr, input logic [1:0] size,
                      input logic uns, input logic [63:0] wdata,
                      input logic [63:0] exp_data, input logic exp_err);
    issue(tag, we, addr, size, uns, wdata, exp_data, exp_err);
    consume(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_addr     = 64'd0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_wdata    = 64'd0;
    rsp_ready    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_rdy",   64'(req_ready), 64'd1);
    check_val("rst_vld",   64'(rsp_valid), 64'd0);
    check_val("rst_rdata", rsp_rdata,      64'd0);
    check_val("rst_err",   64'(rsp_err),   64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    xfer("st_d40",   1'b1, 64'h40, SZ_D, 1'b0, 64'h1122_3344_5566_7788, 64'd0, 1'b0);
    xfer("ld_d40",   1'b0, 64'h40, SZ_D, 1'b0, 64'd0, 64'h1122_3344_5566_7788, 1'b0);
    xfer("st_b43",   1'b1, 64'h43, SZ_B, 1'b0, 64'h1234_5678_9ABC_DEAB, 64'd0, 1'b0);
    xfer("ld_d40b",  1'b0, 64'h40, SZ_D, 1'b0, 64'd0, 64'h1122_3344_AB66_7788, 1'b0);
    xfer("ld_b43s",  1'b0, 64'h43, SZ_B, 1'b0, 64'd0, 64'hFFFF_FFFF_FFFF_FFAB, 1'b0);
    xfer("ld_b43u",  1'b0, 64'h43, SZ_B, 1'b1, 64'd0, 64'h0000_0000_0000_00AB, 1'b0);
    xfer("ld_h46s",  1'b0, 64'h46, SZ_H, 1'b0, 64'd0, 64'h0000_0000_0000_1122, 1'b0);
    xfer("ld_h42s",  1'b0, 64'h42, SZ_H, 1'b0, 64'd0, 64'hFFFF_FFFF_FFFF_AB66, 1'b0);
    xfer("ld_h42u",  1'b0, 64'h42, SZ_H, 1'b1, 64'd0, 64'h0000_0000_0000_AB66, 1'b0);
    xfer("ld_w44s",  1'b0, 64'h44, SZ_W, 1'b0, 64'd0, 64'h0000_0000_1122_3344, 1'b0);
    xfer("ld_w40s",  1'b0, 64'h40, SZ_W, 1'b0, 64'd0, 64'hFFFF_FFFF_AB66_7788, 1'b0);
    xfer("ld_w42mis",1'b0, 64'h42, SZ_W, 1'b0, 64'd0, 64'd0, 1'b1);
    xfer("st_h41mis",1'b1, 64'h41, SZ_H, 1'b0, 64'hFFFF, 64'd0, 1'b1);
    xfer("ld_d40c",  1'b0, 64'h40, SZ_D, 1'b0, 64'd0, 64'h1122_3344_AB66_7788, 1'b0);

    xfer("st_d00",   1'b1, 64'h0,   SZ_D, 1'b0, 64'hCAFE_F00D_DEAD_BEEF, 64'd0, 1'b0);
    xfer("st_d800",  1'b1, 64'h800, SZ_D, 1'b0, 64'h5555_5555_5555_5555, 64'd0, 1'b1);
    xfer("ld_d00",   1'b0, 64'h0,   SZ_D, 1'b0, 64'd0, 64'hCAFE_F00D_DEAD_BEEF, 1'b0);

    // Response held for five cycles while a competing store is presented.
    issue("stall", 1'b0, 64'h40, SZ_D, 1'b0, 64'd0, 64'h1122_3344_AB66_7788, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive_req(1'b1, 64'h40, SZ_D, 1'b0, 64'd0);
      @(posedge clk); #1;
      check_val("stall_vld",   64'(rsp_valid), 64'd1);
      check_val("stall_rdata", rsp_rdata,      64'h1122_3344_AB66_7788);
      check_val("stall_rdy",   64'(req_ready), 64'd0);
    end
    req_valid = 1'b0;
    consume("stall");
    xfer("ld_after_stall", 1'b0, 64'h40, SZ_D, 1'b0, 64'd0, 64'h1122_3344_AB66_7788, 1'b0);

    // Reset during WAIT discards a pending store.
    xfer("st_d80", 1'b1, 64'h80, SZ_D, 1'b0, 64'h0123_4567_89AB_CDEF, 64'd0, 1'b0);
    drive_req(1'b1, 64'h80, SZ_D, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check_val("rstw_vld", 64'(rsp_valid), 64'd0);
    check_val("rstw_rdy", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check_val("rstw_vld2", 64'(rsp_valid), 64'd0);
    check_val("rstw_err",  64'(rsp_err),   64'd0);
    xfer("ld_d80", 1'b0, 64'h80, SZ_D, 1'b0, 64'd0, 64'h0123_4567_89AB_CDEF, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
